// File: rtl/intc_edge_prio.sv
// intc_edge_prio: edge-triggered, fixed-priority interrupt controller in front of the core INT input.
// Async lines are synchronised, rising edges latch sticky pending bits, the lowest-index
// enabled source is presented one-hot until acknowledged, and software reaches the
// PENDING / MASK / STATUS / LAT registers through a small bus slave.
// Optional build macro INTC_LATENCY_CNT_EN adds a request-to-ack latency capture in LAT.
module intc_edge_prio #(
    parameter int unsigned N_IRQ       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    output logic [N_IRQ-1:0] int_out,
    input  logic             int_ack,
    output logic [2:0]       irq_id,
    input  logic             bus_we,
    input  logic [1:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned LAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d, pend_w;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] int_out_q, int_out_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    state_e           state_q, state_d;

    logic [N_IRQ-1:0] rise, w1c, active, sel_oh, win_oh;
    logic [ID_W-1:0]  win_id;
    logic [31:0]      lat_rd;
    logic             unused_wdata;

    assign unused_wdata = ^bus_wdata[31:N_IRQ];

    // Edge detect, W1C strobe and the one-hot of the presented / winning source
    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign w1c    = (bus_we && bus_addr == 2'd0) ? bus_wdata[N_IRQ-1:0] : '0;
    assign active = pend_q & mask_q;
    assign sel_oh = N_IRQ'(1) << irq_id_q;
    assign win_oh = N_IRQ'(1) << win_id;

    // Fixed priority: lowest enabled pending index wins
    always_comb begin
        win_id = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (active[N_IRQ-1-i]) win_id = ID_W'(N_IRQ-1-i);
        end
    end

    // Next state, request output and register updates; new edges always win over clears
    always_comb begin
        state_d   = state_q;
        int_out_d = '0;
        irq_id_d  = irq_id_q;
        mask_d    = mask_q;
        pend_w    = (pend_q & ~w1c) | rise;
        pend_d    = pend_w;
        if (bus_we && bus_addr == 2'd1) mask_d = bus_wdata[N_IRQ-1:0];
        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    irq_id_d  = win_id;
                    int_out_d = win_oh;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    pend_d  = (pend_q & ~w1c & ~sel_oh) | rise;
                    state_d = ST_HOLD;
                end else if (~|(pend_w & mask_d & sel_oh)) begin
                    state_d = ST_IDLE;
                end else begin
                    int_out_d = sel_oh;
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            prev_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            int_out_q <= '0;
            irq_id_q  <= '0;
            state_q   <= ST_IDLE;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q    <= sync_q[SYNC_STAGES-1];
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            int_out_q <= int_out_d;
            irq_id_q  <= irq_id_d;
            state_q   <= state_d;
        end
    end

`ifdef INTC_LATENCY_CNT_EN
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d, lat_inc;
    logic [31:0]      lat_q, lat_d;

    assign lat_inc = (lat_cnt_q == {LAT_W{1'b1}}) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

    // Count cycles spent in REQ, capture on acknowledge together with the source id
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        lat_d     = lat_q;
        if (state_q == ST_IDLE && state_d == ST_REQ) lat_cnt_d = '0;
        else if (state_q == ST_REQ)                  lat_cnt_d = lat_inc;
        if (state_q == ST_REQ && int_ack) lat_d = {16'(irq_id_q), lat_inc};
    end

    // Latency counter and capture register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt_q <= '0;
            lat_q     <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            lat_q     <= lat_d;
        end
    end

    assign lat_rd = lat_q;
`else
    assign lat_rd = '0;
`endif

    // Combinational register read-back
    always_comb begin
        case (bus_addr)
            2'd0:    bus_rdata = 32'(pend_q);
            2'd1:    bus_rdata = 32'(mask_q);
            2'd2:    bus_rdata = 32'({state_q, irq_id_q});
            default: bus_rdata = lat_rd;
        endcase
    end

    assign int_out = int_out_q;
    assign irq_id  = irq_id_q;

endmodule

// File: doc/intc_edge_prio.md
Name: intc_edge_prio

Overview:
- Interrupt controller sitting directly upstream of the MIPS core's 4-bit INT input.
- Synchronises asynchronous external interrupt lines and detects rising edges into sticky pending bits.
- Applies a software mask, picks one source by fixed priority and drives it one-hot to the core, holding it until the core acknowledges.
- Software reads and clears its registers through a small memory-mapped slave port on the data-memory bus.

Parameters:
N_IRQ, 4, number of interrupt sources; must equal the core's INT width (legal 1..8)
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (legal 2..3)

Ports:
clk  in  1  system clock; same clock as the core
rst  in  1  asynchronous, active-low reset (0 = reset)
irq_in  in  N_IRQ  external asynchronous interrupt lines, active-high
int_out  out  N_IRQ  one-hot interrupt request to core INT input
int_ack  in  1  core acknowledge; single-cycle pulse when vector is taken
irq_id  out  3  index of the currently presented source
bus_we  in  1  register write strobe
bus_addr  in  2  register select (word index)
bus_wdata  in  32  write data
bus_rdata  out  32  read data, combinational from bus_addr

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, pending=0 and mask=0 (all masked). Synchroniser flops and edge-detect history are 0. FSM goes to IDLE.
- Reset mid-operation: any asserted int_out drops immediately and no pending state survives.
- Synchroniser: SYNC_STAGES flops per line; an edge-detect flop holds the previous synchronised value.
- Pending set: pending[i] sets on a synchronised 0->1 transition of line i. A line held high does not re-trigger.
- Pending latency: with SYNC_STAGES=2, the pending bit is visible at the 3rd rising clk edge after irq_in rises. irq_in must be high for at least 2 clk periods to be captured.
- Register map:
  - addr 0 PENDING: read returns pending; write-1-to-clear per bit.
  - addr 1 MASK: read/write; 1 = enabled.
  - addr 2 STATUS: [2:0] = irq_id, [4:3] = FSM state.
  - addr 3 LAT: see Optional Feature; reads 0 when compiled out.
  - Upper unused bits read 0.
- Set/clear collision: if a new edge on bit i and a W1C of bit i land in the same cycle, set wins.
- Mask: a masked pending bit stays pending and is presented once it is unmasked.
- Priority: lowest index wins among (pending & mask).
- FSM (all transitions on rising clk):
  - IDLE: int_out=0. If (pending & mask) != 0, latch the winner into irq_id and go to REQ. int_out asserts on the same edge (registered, one cycle after pending is visible).
  - REQ: int_out = one-hot(irq_id), held steady. A higher-priority arrival does not pre-empt.
    - If int_ack=1: clear pending[irq_id] and go to HOLD; int_out=0 on that edge.
    - If software W1C-clears or masks the presented bit before ack: withdraw, int_out=0 next edge, go to IDLE.
  - HOLD: one dead cycle with int_out=0, so the core sees a falling edge between requests; then go to IDLE.
- int_ack seen while in IDLE or HOLD is ignored.
- A new edge on the presented source that arrives in the same cycle as int_ack re-sets its pending bit; set wins.
- Back-to-back service: with two bits pending, the gap between the first int_out falling and the second rising is exactly 2 cycles (HOLD, then IDLE).

Optional Feature:
INTC_LATENCY_CNT_EN
- Defined:
  - A 16-bit saturating counter clears on the IDLE->REQ transition and increments every cycle in REQ.
  - On int_ack the count is copied into LAT[15:0]. LAT[31:16] holds the irq_id of that capture.
  - The counter saturates at 0xFFFF. LAT resets to 0.
- Not defined: no counter logic is built, and addr 3 reads 0.

Test Plan:
- Reset: rst=0 with irq_in=4'hF -> int_out=0, PENDING=0, MASK=0. Release rst, hold 10 cycles -> PENDING=4'hF, int_out stays 0 (all masked).
- Single IRQ: MASK=4'hF; pulse irq_in[2] high for 3 cycles -> PENDING=4'h4 after 3 edges; int_out=4'b0100 and irq_id=2 one cycle later. int_ack pulse -> int_out=0 next edge, PENDING=0.
- Priority and back-to-back: PENDING=4'b1010, MASK=4'hF -> int_out=4'b0010. After ack: 2 cycles of 0, then int_out=4'b1000, irq_id=3.
- Mask and W1C: MASK=4'h1; raise irq_in[3] -> no int_out, PENDING=4'h8. Write MASK=4'h8 -> int_out=4'b1000. W1C addr0=4'h8 before ack -> int_out=0, FSM back in IDLE.
- Collision: in REQ for irq 1, apply int_ack in the same cycle irq 1's synchronised edge arrives -> PENDING[1] remains 1 and irq 1 is re-presented after HOLD.
- With INTC_LATENCY_CNT_EN: ack 7 cycles after int_out rises for irq 0 -> LAT reads 32'h0000_0007. Hold REQ for 70000 cycles -> LAT[15:0]=16'hFFFF.
